recon_fb_writer: RTL and testbench
==================================

// Module: recon_fb_writer
// PURPOSE
//  Write-back end of the intra reconstruction loop. Accepts one reconstructed block
//  (luma 4x4 or chroma 8x8) with its block number and writes it row by row into the
//  reconstructed frame store. Neighbour extraction for later blocks reads that store.
//  Instantiate once per plane (luma, chroma-B, chroma-R).
// PARAMETERS
//  WIDTH      1280  frame width in pixels
//  LENGTH     720   frame height in pixels
//  MB_SIZE_L  4     block height (rows)
//  MB_SIZE_W  4     block width (pixels per row = pixels per memory write)
//  ADDR_W     20    pixel address width; 2**ADDR_W >= WIDTH*LENGTH
// PORTS
//  clk       in   1               clock
//  reset     in   1               synchronous, active-high reset
//  in_valid  in   1               block + mbnumber valid
//  in_ready  out  1               writer can accept a block
//  mbnumber  in   32              raster block index (0 = top-left)
//  pixels    in   8 x L*W         unpacked [7:0] [MB_SIZE_L*MB_SIZE_W-1:0]; index r*MB_SIZE_W+c
//  wr_en     out  1               frame-store write strobe
//  wr_addr   out  ADDR_W          pixel address of leftmost pixel of the row
//  wr_data   out  8*MB_SIZE_W     wr_data[8c+7:8c] = pixel(r,c)
//  wr_ready  in   1               frame store accepts write this cycle
//  done      out  1               one-cycle pulse: block fully written
//  err       out  1               one-cycle pulse: mbnumber out of range, block dropped
// BEHAVIOUR
//  - Reset: in_ready=0 in the reset cycle, then 1 (IDLE); wr_en=0, wr_addr=0,
//    wr_data=0, done=0, err=0. Pixel buffer and row counter cleared.
//  - Handshake: block accepted on in_valid & in_ready. in_ready=1 only in IDLE.
//    Pixels and mbnumber are captured into an internal buffer at acceptance, so
//    the inputs may change afterwards.
//  - Constants: MBS_PER_ROW=WIDTH/MB_SIZE_W; MB_TOTAL=MBS_PER_ROW*(LENGTH/MB_SIZE_L).
//  - FSM IDLE -> ADDR -> WRITE -> DONE -> IDLE.
//    IDLE : wait for handshake.
//    ADDR : 1 cycle. mb_x=mbnumber%MBS_PER_ROW, mb_y=mbnumber/MBS_PER_ROW.
//           base=mb_y*MB_SIZE_L*WIDTH+mb_x*MB_SIZE_W, registered.
//           If mbnumber>=MB_TOTAL: pulse err next cycle and return to IDLE (no wr_en).
//    WRITE: wr_en=1, wr_addr=base+row*WIDTH, wr_data=buffer row 'row'.
//           row increments only on wr_en & wr_ready. If wr_ready=0, addr/data/en hold stable.
//           After the transfer of row MB_SIZE_L-1 -> DONE.
//    DONE : done=1 for exactly one cycle, wr_en=0 -> IDLE (in_ready=1 next cycle).
//  - Latency (wr_ready tied 1): handshake at cycle 0, ADDR at 1, rows at 2..MB_SIZE_L+1,
//    done at MB_SIZE_L+2, next handshake possible at MB_SIZE_L+3.
//  - Arithmetic: address math is unsigned, ADDR_W bits. Last row of the last block
//    ends exactly at WIDTH*LENGTH-1, so no wrap occurs for legal mbnumber.
//  - Reset mid-operation (ADDR/WRITE/DONE): abort immediately. No further wr_en,
//    no done pulse, and the partial block is not completed.
//  - in_valid held high while busy is ignored. It is not consumed until IDLE.
// STRUCTURE
//  - Shared package (intra_pkg): state enum {IDLE,ADDR,WRITE,DONE}, PIXEL_W=8, and
//    a function mb_base_addr(mbnumber) used here and by the neighbour extractor.
//  - No sub-module. FSM, row counter and pixel buffer live in one module.
//    Divide/modulo by the constant MBS_PER_ROW stay inside the ADDR state.
// TESTING
//  1 4x4, mbnumber=0, pixels=index, wr_ready=1 -> addr 0,1280,2560,3840.
//    Row 0 data = 0x03020100. done at cycle 6.
//  2 4x4, mbnumber=321 -> addr 5124,6404,7684,8964.
//    mbnumber=57599 -> last addr 921596.
//  3 8x8 (MB_SIZE_L=W=8), mbnumber=160 -> 8 writes from 10240, step 1280, 64-bit data.
//  4 mbnumber=57600 (4x4) -> err pulse at cycle 2, zero wr_en, in_ready=1 at cycle 3.
//  5 wr_ready low for 3 cycles during row 1 -> wr_addr=1280 and wr_data held stable.
//    Exactly 4 transfers. done delayed by 3 cycles.
//  6 reset asserted during row 2 -> wr_en=0 next cycle, no done, in_ready=1 after release.

Source files
------------

// File: rtl/intra_pkg.sv
// Shared definitions for the intra reconstruction loop: FSM states, pixel width
// and the block-number to frame-store base-address mapping.
package intra_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, WRITE, DONE} state_t;

  localparam int PIXEL_W = 8;

  // Pixel address of the top-left pixel of raster block mbnumber.
  function automatic logic [31:0] mb_base_addr(
    input logic [31:0] mbnumber,
    input int unsigned mbs_per_row,
    input int unsigned mb_l,
    input int unsigned mb_w,
    input int unsigned width
  );
    logic [31:0] mb_x;
    logic [31:0] mb_y;
    mb_x = mbnumber % mbs_per_row;
    mb_y = mbnumber / mbs_per_row;
    return mb_y * mb_l * width + mb_x * mb_w;
  endfunction

endpackage

// File: rtl/recon_fb_writer.sv
// Writes one reconstructed block, row by row, into the reconstructed frame store.
// One instance per plane; block geometry is set by MB_SIZE_L x MB_SIZE_W.
module recon_fb_writer
  import intra_pkg::*;
#(
  parameter int WIDTH     = 1280,
  parameter int LENGTH    = 720,
  parameter int MB_SIZE_L = 4,
  parameter int MB_SIZE_W = 4,
  parameter int ADDR_W    = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  mbnumber,
  input  logic [PIXEL_W-1:0]           pixels [MB_SIZE_L*MB_SIZE_W-1:0],
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [PIXEL_W*MB_SIZE_W-1:0] wr_data,
  input  logic                         wr_ready,
  output logic                         done,
  output logic                         err
);

  localparam int NPIX        = MB_SIZE_L * MB_SIZE_W;
  localparam int MBS_PER_ROW = WIDTH / MB_SIZE_W;
  localparam int MB_TOTAL    = MBS_PER_ROW * (LENGTH / MB_SIZE_L);
  localparam int ROW_W       = (MB_SIZE_L > 1) ? $clog2(MB_SIZE_L) : 1;

  state_t               state;
  state_t               state_nxt;
  logic [31:0]          mb_p0;
  logic [PIXEL_W-1:0]   pix_p0 [NPIX-1:0];
  logic [ADDR_W-1:0]    base_p1;
  logic                 oob_p1;
  logic [ROW_W-1:0]     row_cnt;
  logic                 oob;

  assign oob = (mb_p0 >= 32'(MB_TOTAL));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Capture stage: block latched at acceptance so the producer may move on.
  // Address stage: base and range flag registered during ADDR.
  always_ff @(posedge clk) begin
    if (reset) begin
      mb_p0   <= '0;
      base_p1 <= '0;
      oob_p1  <= 1'b0;
      row_cnt <= '0;
      for (int i = 0; i < NPIX; i++) pix_p0[i] <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        mb_p0  <= mbnumber;
        pix_p0 <= pixels;
      end
      if (state == ADDR) begin
        base_p1 <= ADDR_W'(mb_base_addr(mb_p0, MBS_PER_ROW, MB_SIZE_L, MB_SIZE_W, WIDTH));
        oob_p1  <= oob;
        row_cnt <= '0;
      end
      if (state == WRITE && wr_ready) row_cnt <= row_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid && !reset) state_nxt = ADDR;
      end
      ADDR: state_nxt = oob ? DONE : WRITE;
      WRITE: begin
        wr_en = 1'b1;
        if (wr_ready && row_cnt == ROW_W'(MB_SIZE_L - 1)) state_nxt = DONE;
      end
      DONE: begin
        // An out-of-range block reuses DONE so err lands one cycle after ADDR.
        done      = ~oob_p1;
        err       = oob_p1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (state == WRITE) begin
      wr_addr = base_p1 + ADDR_W'(row_cnt) * ADDR_W'(WIDTH);
      for (int c = 0; c < MB_SIZE_W; c++)
        wr_data[PIXEL_W*c +: PIXEL_W] = pix_p0[int'(row_cnt)*MB_SIZE_W + c];
    end
  end

endmodule

// File: tb/tb_recon_fb_writer.sv
// Directed bench for recon_fb_writer: a 4x4 luma instance and an 8x8 chroma instance.
module tb_recon_fb_writer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 4x4 instance
  logic        a_in_valid, a_in_ready, a_wr_en, a_wr_ready, a_done, a_err;
  logic [31:0] a_mb;
  logic [7:0]  a_pix [15:0];
  logic [19:0] a_wr_addr;
  logic [31:0] a_wr_data;

  recon_fb_writer #(.WIDTH(1280), .LENGTH(720), .MB_SIZE_L(4), .MB_SIZE_W(4), .ADDR_W(20)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mbnumber(a_mb), .pixels(a_pix), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_ready(a_wr_ready), .done(a_done), .err(a_err)
  );

  // 8x8 instance
  logic        b_in_valid, b_in_ready, b_wr_en, b_done, b_err;
  logic [31:0] b_mb;
  logic [7:0]  b_pix [63:0];
  logic [19:0] b_wr_addr;
  logic [63:0] b_wr_data;

  recon_fb_writer #(.WIDTH(1280), .LENGTH(720), .MB_SIZE_L(8), .MB_SIZE_W(8), .ADDR_W(20)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mbnumber(b_mb), .pixels(b_pix), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_ready(1'b1), .done(b_done), .err(b_err)
  );

  // Monitors sample on the falling edge, away from the DUT's active edge.
  logic [19:0] a_addr_q[$], a_stall_addr_q[$], b_addr_q[$];
  logic [31:0] a_data_q[$], a_stall_data_q[$];
  logic [63:0] b_data_q[$];
  int a_hs = 0, a_done_cnt = 0, a_err_cnt = 0, a_en_cnt = 0;
  int a_done_rel = -1, a_err_rel = -1, a_rdy_rel = -1;
  bit a_rdy_pend = 0;
  int b_hs = 0, b_done_rel = -1;

  always @(negedge clk) begin
    if (a_in_ready && a_rdy_pend) begin a_rdy_rel = cyc - a_hs; a_rdy_pend = 0; end
    if (a_in_valid && a_in_ready) begin a_hs = cyc; a_rdy_pend = 1; end
    if (a_wr_en) a_en_cnt++;
    if (a_wr_en && a_wr_ready) begin a_addr_q.push_back(a_wr_addr); a_data_q.push_back(a_wr_data); end
    if (a_wr_en && !a_wr_ready) begin a_stall_addr_q.push_back(a_wr_addr); a_stall_data_q.push_back(a_wr_data); end
    if (a_done) begin a_done_cnt++; a_done_rel = cyc - a_hs; end
    if (a_err)  begin a_err_cnt++;  a_err_rel  = cyc - a_hs; end
    if (b_in_valid && b_in_ready) b_hs = cyc;
    if (b_wr_en) begin b_addr_q.push_back(b_wr_addr); b_data_q.push_back(b_wr_data); end
    if (b_done) b_done_rel = cyc - b_hs;
  end

  task automatic clear_a();
    a_addr_q.delete(); a_data_q.delete(); a_stall_addr_q.delete(); a_stall_data_q.delete();
    a_done_rel = -1; a_err_rel = -1; a_rdy_rel = -1;
  endtask

  // Presents one block; returns one cycle after the handshake edge.
  task automatic send_a(input logic [31:0] mb, input logic [7:0] pbase);
    clear_a();
    @(posedge clk); #1;
    a_mb = mb;
    for (int i = 0; i < 16; i++) a_pix[i] = pbase + 8'(i);
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_mb = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) a_pix[i] = 8'hEE;
  endtask

  int en_before, done_before;

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_wr_ready = 1'b1; a_mb = '0;
    b_in_valid = 1'b0; b_mb = '0;
    for (int i = 0; i < 16; i++) a_pix[i] = '0;
    for (int i = 0; i < 64; i++) b_pix[i] = '0;

    @(negedge clk);
    chk("rst_in_ready", a_in_ready, 0);
    @(negedge clk);
    chk("rst_wr_en", a_wr_en, 0);
    chk("rst_wr_addr", a_wr_addr, 0);
    chk("rst_wr_data", a_wr_data, 0);
    chk("rst_done_err", {a_done, a_err}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", a_in_ready, 1);

    // Block 0, pixels = index
    send_a(32'd0, 8'h00);
    repeat (10) @(posedge clk);
    chk("t1_nwr", a_addr_q.size(), 4);
    if (a_addr_q.size() == 4) begin
      chk("t1_addr0", a_addr_q[0], 0);
      chk("t1_addr1", a_addr_q[1], 1280);
      chk("t1_addr2", a_addr_q[2], 2560);
      chk("t1_addr3", a_addr_q[3], 3840);
      chk("t1_data0", a_data_q[0], 32'h03020100);
      chk("t1_data3", a_data_q[3], 32'h0F0E0D0C);
    end
    chk("t1_done_cyc", a_done_rel, 6);
    chk("t1_ready_cyc", a_rdy_rel, 7);

    // Interior block and the final block of the frame
    send_a(32'd321, 8'h20);
    repeat (10) @(posedge clk);
    chk("t2_nwr", a_addr_q.size(), 4);
    if (a_addr_q.size() == 4) begin
      chk("t2_addr0", a_addr_q[0], 5124);
      chk("t2_addr3", a_addr_q[3], 8964);
      chk("t2_data1", a_data_q[1], 32'h27262524);
    end
    send_a(32'd57599, 8'h10);
    repeat (10) @(posedge clk);
    chk("t2_last_nwr", a_addr_q.size(), 4);
    if (a_addr_q.size() == 4) begin
      chk("t2_last_addr", a_addr_q[3], 921596);
      chk("t2_last_data", a_data_q[3], 32'h1F1E1D1C);
    end

    // Out-of-range block
    en_before = a_en_cnt; done_before = a_done_cnt;
    send_a(32'd57600, 8'h00);
    repeat (10) @(posedge clk);
    chk("t4_err_cyc", a_err_rel, 2);
    chk("t4_err_cnt", a_err_cnt, 1);
    chk("t4_no_wr_en", a_en_cnt - en_before, 0);
    chk("t4_no_done", a_done_cnt - done_before, 0);
    chk("t4_ready_cyc", a_rdy_rel, 3);

    // Back-pressure during row 1
    send_a(32'd0, 8'h40);
    repeat (2) @(posedge clk); #1 a_wr_ready = 1'b0;
    repeat (3) @(posedge clk); #1 a_wr_ready = 1'b1;
    repeat (10) @(posedge clk);
    chk("t5_nwr", a_addr_q.size(), 4);
    chk("t5_nstall", a_stall_addr_q.size(), 3);
    if (a_stall_addr_q.size() == 3) begin
      chk("t5_stall_addr0", a_stall_addr_q[0], 1280);
      chk("t5_stall_addr2", a_stall_addr_q[2], 1280);
      chk("t5_stall_data2", a_stall_data_q[2], 32'h47464544);
    end
    if (a_addr_q.size() == 4) chk("t5_addr1", a_addr_q[1], 1280);
    chk("t5_done_cyc", a_done_rel, 9);

    // Reset while row 2 is presented
    done_before = a_done_cnt;
    send_a(32'd0, 8'h00);
    repeat (3) @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_wr_en_after_rst", a_wr_en, 0);
    chk("t6_in_ready_after_rst", a_in_ready, 1);
    repeat (10) @(posedge clk);
    chk("t6_no_done", a_done_cnt - done_before, 0);
    chk("t6_nwr", a_addr_q.size(), 3);

    // 8x8 block 160
    @(posedge clk); #1;
    b_mb = 32'd160;
    for (int i = 0; i < 64; i++) b_pix[i] = 8'(i);
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 64; i++) b_pix[i] = 8'hEE;
    repeat (15) @(posedge clk);
    chk("t3_nwr", b_addr_q.size(), 8);
    if (b_addr_q.size() == 8) begin
      chk("t3_addr0", b_addr_q[0], 10240);
      chk("t3_addr1", b_addr_q[1], 11520);
      chk("t3_addr7", b_addr_q[7], 19200);
      chk("t3_data0", b_data_q[0], 64'h0706050403020100);
      chk("t3_data7", b_data_q[7], 64'h3F3E3D3C3B3A3938);
    end
    chk("t3_done_cyc", b_done_rel, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
